// File: rtl/add_sub_pkg.sv
// Shared types and helpers for the sequential add/subtract block.
//   state_e      : controller states (idle / chunk calculation / result hold)
//   MODE_ADD/SUB : encoding of the Cin mode input
//   calc_nchunk  : number of CHUNK-bit slices in a WIDTH-bit operand
package add_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/add_sub_chunk.sv
// Combinational CHUNK-bit adder slice with optional inversion of y.
//   a, y  : slice operands
//   sub   : 1 = use ~y (subtract), 0 = use y
//   cin   : carry into the slice
//   s     : slice sum
//   cout  : carry out of the slice
module add_sub_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] y,
  input  logic         sub,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W-1:0] y_eff;
  logic [W:0]   sum;

  assign y_eff = sub ? ~y : y;
  assign sum   = {1'b0, a} + {1'b0, y_eff} + {{W{1'b0}}, cin};
  assign s     = sum[W-1:0];
  assign cout  = sum[W];

endmodule

// File: rtl/add_sub_seq_nb.sv
// Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per cycle, LSB first,
// carry registered between cycles, valid/ready on both sides.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (ready only while idle)
//   A, Y                 : operands
//   Cin                  : mode, 0 = A+Y, 1 = A-Y
//   out_valid / out_ready: result handshake
//   S, Cout, OVF         : result, MSB carry, signed overflow of raw result
// Build option: define ADD_SUB_SATURATE_EN to clamp S to the signed limit on
// overflow (OVF and Cout still describe the unclamped result).
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready for operands; accepts on in_valid
// ST_CALC | one chunk per cycle into S; carry kept in carry_q
// ST_DONE | result held until out_ready
module add_sub_seq_nb
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             OVF
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             mode_q, mode_d;
  logic             carry_q, carry_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_c, y_c, sum_c;
  logic             cout_c;
  logic [WIDTH-1:0] s_merge;
  logic             ovf_raw;

  // Select the operand slices addressed by the chunk index.
  always_comb begin
    a_c = '0;
    y_c = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_c = a_q[i*CHUNK +: CHUNK];
        y_c = y_q[i*CHUNK +: CHUNK];
      end
    end
  end

  add_sub_chunk #(.W(CHUNK)) u_chunk (
    .a    (a_c),
    .y    (y_c),
    .sub  (mode_q == MODE_SUB),
    .cin  (carry_q),
    .s    (sum_c),
    .cout (cout_c)
  );

  // Current S with this cycle's slice written in; on the last slice this is
  // the complete raw result used for the overflow test.
  always_comb begin
    s_merge = s_q;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) begin
        s_merge[i*CHUNK +: CHUNK] = sum_c;
      end
    end
  end

  // Overflow: operands of equal sign (Y taken as inverted when subtracting)
  // producing a result of the other sign.
  assign ovf_raw = (a_q[WIDTH-1] == (y_q[WIDTH-1] ^ mode_q)) &&
                   (s_merge[WIDTH-1] != a_q[WIDTH-1]);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    y_d     = y_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          y_d     = Y;
          mode_d  = Cin;
          carry_d = Cin;
          idx_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        s_d     = s_merge;
        carry_d = cout_c;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          cout_d  = cout_c;
          ovf_d   = ovf_raw;
          state_d = ST_DONE;
`ifdef ADD_SUB_SATURATE_EN
          if (ovf_raw) begin
            s_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
          end
`endif
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      y_q     <= '0;
      mode_q  <= MODE_ADD;
      carry_q <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign S         = s_q;
  assign Cout      = cout_q;
  assign OVF       = ovf_q;

endmodule
